// File: rtl/dm_pkg.sv
// Shared types and constants for the datapath data memory.
package dm_pkg;

  localparam int DM_WIDTH      = 32;
  localparam int DM_DEPTH_LOG2 = 8;

  typedef logic [DM_WIDTH-1:0] dm_word_t;

  localparam dm_word_t DM_RESET_WORD = '0;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory for the memory stage: synchronous writes, combinational
// gated reads, whole-array clear on asynchronous active-low reset.
module data_memory
  import dm_pkg::*;
#(
  parameter int WIDTH      = DM_WIDTH,
  parameter int DEPTH_LOG2 = DM_DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             zero,
  input  logic             MemWrite,
  input  logic             MemRead,
  output logic [WIDTH-1:0] ReadData
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] index;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic                  unused_bits;

  // Upper address bits wrap away; the zero flag only passes through this stage.
  assign index       = result[DEPTH_LOG2-1:0];
  assign unused_bits = ^{zero, result[WIDTH-1:DEPTH_LOG2]};

  always_comb begin
    mem_d = mem_q;
    if (MemWrite) begin
      mem_d[index] = WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(DM_RESET_WORD);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && rst_n) begin
      ReadData = mem_q[index];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory against an array-based reference model.
module tb_data_memory;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] result;
  logic [31:0] WriteData;
  logic        zero;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;

  logic [31:0] model [256];
  sb_item_t    sb_q [$];
  event        check_ev;
  int          n_vec;
  int          n_miss;

  data_memory #(.WIDTH(32), .DEPTH_LOG2(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .result    (result),
    .WriteData (WriteData),
    .zero      (zero),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value follows straight from the rules: zero unless reading out of reset.
  function automatic logic [31:0] model_read();
    if (MemRead !== 1'b1 || rst_n !== 1'b1) return 32'h0;
    return model[int'(result % 256)];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  endtask

  task automatic check_output(input string name);
    sb_item_t item;
    item.name = name;
    item.exp  = model_read();
    sb_q.push_back(item);
    ->check_ev;
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d,
                                input logic we, input logic re, input logic z,
                                input string name);
    @(negedge clk);
    result = a; WriteData = d; MemWrite = we; MemRead = re; zero = z;
    #1;
    check_output({name, "_pre"});
    @(posedge clk);
    if (we && rst_n) model[int'(a % 256)] = d;
    #1;
    check_output({name, "_post"});
  endtask

  task automatic read_at(input logic [31:0] a, input string name);
    @(negedge clk);
    result = a; MemWrite = 1'b0; MemRead = 1'b1;
    #1;
    check_output(name);
  endtask

  // Monitor: every check strobe pops one expectation and compares the live output.
  initial begin
    sb_item_t item;
    forever begin
      @(check_ev);
      n_vec++;
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("[TB] FAIL scoreboard_empty got=%h", ReadData);
      end else begin
        item = sb_q.pop_front();
        if (ReadData !== item.exp) begin
          n_miss++;
          $display("[TB] FAIL %s got=%h exp=%h at t=%0t", item.name, ReadData, item.exp, $time);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_miss = 0;
    result = 0; WriteData = 0; zero = 0; MemWrite = 0; MemRead = 0;
    rst_n = 1'b1;
    model_clear();
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    // Post-reset reads
    @(negedge clk);
    result = 1; MemRead = 1; #1; check_output("reset_read1");
    result = 0; MemRead = 0; #1; check_output("reset_noread0");

    // Simple write then reads
    apply_stimulus(32'd6, 32'd1, 1'b1, 1'b0, 1'b0, "wr6");
    read_at(32'd6, "rd6");
    read_at(32'd5, "rd5");

    // Same-index read/write, zero toggled
    @(negedge clk);
    result = 7; WriteData = 1; MemWrite = 1; MemRead = 1; zero = 0;
    #1; check_output("rw7_pre");
    zero = 1; #1; check_output("rw7_pre_zero");
    @(posedge clk);
    model[7] = 32'd1;
    #1; check_output("rw7_post");
    zero = 0; #1; check_output("rw7_post_zero");

    // Address wrap
    apply_stimulus(32'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, "wr3");
    read_at(32'd259, "rd259");
    apply_stimulus(32'd259, 32'h12345678, 1'b1, 1'b0, 1'b1, "wr259");
    read_at(32'd3, "rd3");

    // Reset pulse between edges, with a write edge inside reset
    apply_stimulus(32'd2, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, "wr2");
    read_at(32'd2, "rd2_before_rst");
    #2 rst_n = 1'b0;
    model_clear();
    #1; check_output("rst_immediate");
    WriteData = 32'h55AA55AA; MemWrite = 1;
    @(posedge clk);
    #1; check_output("rst_edge_write");
    @(negedge clk);
    MemWrite = 0;
    #2 rst_n = 1'b1;
    #1; check_output("rd2_after_rst");
    read_at(32'd2, "rd2_after_rst_b");

    // Write without read keeps output at zero
    apply_stimulus(32'd4, 32'd1, 1'b1, 1'b0, 1'b0, "wr4_noread");
    read_at(32'd4, "rd4");

    // Unknown address with both enables low across an edge
    @(negedge clk);
    result = 'x; WriteData = 32'hFFFFFFFF; MemWrite = 0; MemRead = 0;
    @(posedge clk);
    #1;
    read_at(32'd6, "x_rd6");
    read_at(32'd7, "x_rd7");

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_clear();
        MemRead = 1'b1; result = a;
        #1; check_output("rnd_rst");
        #3 rst_n = 1'b1;
      end
      apply_stimulus(a, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), "rnd");
    end

    // Full sweep of the array
    for (int i = 0; i < 256; i++) begin
      read_at(32'(i) + 32'(256 * $urandom_range(0, 3)), "sweep");
    end

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) #1;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
